prng_sample_fifo: RTL

//   Downstream consumer of the N-bit PRNG output word. Samples the free-running

---
 rtl/prng_pkg.sv | 19 +
 rtl/prng_fifo_mem.sv | 29 ++
 rtl/prng_sample_fifo.sv | 133 +++++++++++++
 3 files changed

// File: rtl/prng_pkg.sv
// ============================================================================
// prng_pkg : shared PRNG word width, sample FIFO depth and pointer-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package prng_pkg;

  localparam int PRNG_W     = 32;
  localparam int FIFO_DEPTH = 8;

  // One extra MSB beyond the address bits lets the pointers tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prng_fifo_mem.sv
// ============================================================================
// prng_fifo_mem : DEPTH x N register array, synchronous write, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module prng_fifo_mem #(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [N-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [N-1:0]             rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/prng_sample_fifo.sv
// ============================================================================
// prng_sample_fifo : decimated PRNG sampler feeding a show-ahead valid/ready
//   FIFO; optional stuck-source detector enabled by macro PRNG_HEALTH_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module prng_sample_fifo
  import prng_pkg::*;
#(
  parameter int N     = PRNG_W,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int DECIM = 1
`ifdef PRNG_HEALTH_EN
  , parameter int REP_LIMIT = 4
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N-1:0]              rnd_in,
  input  logic                      rnd_in_en,
  output logic [N-1:0]              m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ptr_w(DEPTH)-1:0]   level,
  output logic                      overflow,
  output logic                      health_fail
);

  localparam int c_PW = ptr_w(DEPTH);
  localparam int c_AW = c_PW - 1;
  localparam int c_CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [c_PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_CW-1:0] cnt_q, cnt_d;
  logic            overflow_q, overflow_d;
  logic            w_full, w_empty, w_pop, w_sample, w_accept, w_wr;
  logic [N-1:0]    w_rdata;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[c_PW-1] != rd_ptr_q[c_PW-1]) &&
                   (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign w_pop    = !w_empty && m_ready;
  assign w_sample = rnd_in_en && (cnt_q == c_CW'(DECIM - 1));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_wr     = w_accept && (!w_full || w_pop);

  always_comb begin
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (rnd_in_en) cnt_d = w_sample ? '0 : cnt_q + c_CW'(1);
    if (w_wr)      wr_ptr_d = wr_ptr_q + c_PW'(1);
    if (w_pop)     rd_ptr_d = rd_ptr_q + c_PW'(1);
    if (w_accept && w_full && !w_pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PRNG_HEALTH_EN
  localparam int c_RW = $clog2(REP_LIMIT + 1);

  logic [N-1:0]    last_q, last_d;
  logic [c_RW-1:0] run_q, run_d;
  logic            health_q, health_d;
  logic            w_trip;

  // run_q==0 means no word has been seen since reset, so nothing to compare with.
  always_comb begin
    last_d   = last_q;
    run_d    = run_q;
    health_d = health_q;
    w_trip   = 1'b0;
    if (w_sample && !health_q) begin
      run_d  = ((run_q != '0) && (rnd_in == last_q)) ? run_q + c_RW'(1) : c_RW'(1);
      last_d = rnd_in;
      w_trip = (run_d == c_RW'(REP_LIMIT));
      if (w_trip) health_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q   <= '0;
      run_q    <= '0;
      health_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      run_q    <= run_d;
      health_q <= health_d;
    end
  end

  assign w_accept    = w_sample && !health_q && !w_trip;
  assign health_fail = health_q;
`else
  assign w_accept    = w_sample;
  assign health_fail = 1'b0;
`endif

  prng_fifo_mem #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_wr),
    .waddr_i (wr_ptr_q[c_AW-1:0]),
    .wdata_i (rnd_in),
    .raddr_i (rd_ptr_q[c_AW-1:0]),
    .rdata_o (w_rdata)
  );

  assign m_valid  = !w_empty;
  assign m_data   = w_empty ? '0 : w_rdata;
  assign level    = wr_ptr_q - rd_ptr_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire
